// File: rtl/rf_multi.sv
// rf_multi: NUM_REGS x WORD_SIZE register file with per-register pending scoreboard and a one-entry-per-cycle clear sweep.
// Define RF_BYPASS_EN to forward a same-cycle write (and its pending state) straight onto the read ports.
module rf_multi #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    rd_addr1,
    output logic [WORD_SIZE-1:0] rd_data1,
    output logic                 pend1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic [WORD_SIZE-1:0] rd_data2,
    output logic                 pend2,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_addr,
    input  logic                 clr_req,
    output logic                 clr_busy
);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  pend_q, pend_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            regs_q  <= regs_d;
        end
    end

    // Reserve is applied after the write so a same-address reserve leaves the entry pending.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        regs_d  = regs_q;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    regs_d[wr_addr] = wr_data;
                    pend_d[wr_addr] = 1'b0;
                end
                if (rsv_en) begin
                    pend_d[rsv_addr] = 1'b1;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[idx_q] = '0;
                pend_d[idx_q] = 1'b0;
                idx_d         = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_busy = (state_q == CLEAR);

    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        pend1    = pend_q[rd_addr1];
        rd_data2 = regs_q[rd_addr2];
        pend2    = pend_q[rd_addr2];
`ifdef RF_BYPASS_EN
        if (wr_en && state_q == IDLE && rd_addr1 == wr_addr) begin
            rd_data1 = wr_data;
            pend1    = rsv_en && (rsv_addr == wr_addr);
        end
        if (wr_en && state_q == IDLE && rd_addr2 == wr_addr) begin
            rd_data2 = wr_data;
            pend2    = rsv_en && (rsv_addr == wr_addr);
        end
`endif
    end

endmodule

// File: tb/tb_rf_multi.sv
// Self-checking bench for rf_multi: directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_multi;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  rd_addr1 = '0, rd_addr2 = '0;
    logic [15:0] rd_data1, rd_data2;
    logic        pend1, pend2;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [2:0]  rsv_addr = '0;
    logic        clr_req = 1'b0;
    logic        clr_busy;

    int n_checks = 0;
    int n_fail   = 0;

    rf_multi #(.WORD_SIZE(16), .NUM_REGS(8), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .pend1(pend1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .pend2(pend2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain arrays plus a sweep position that counts through the file.
    logic [15:0] m_regs [8];
    bit          m_pend [8];
    bit          m_busy;
    int          m_pos;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = 16'h0;
                m_pend[i] = 1'b0;
            end
            m_busy = 1'b0;
            m_pos  = 0;
        end else if (m_busy) begin
            m_regs[m_pos] = 16'h0;
            m_pend[m_pos] = 1'b0;
            m_pos++;
            if (m_pos == 8) m_busy = 1'b0;
        end else begin
            if (wr_en) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv_en) m_pend[rsv_addr] = 1'b1;
            if (clr_req) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end
    end

    function automatic logic [15:0] exp_data(input logic [2:0] a);
`ifdef RF_BYPASS_EN
        if (wr_en && !m_busy && a == wr_addr) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_pend(input logic [2:0] a);
`ifdef RF_BYPASS_EN
        if (wr_en && !m_busy && a == wr_addr) return rsv_en && (rsv_addr == wr_addr);
`endif
        return m_pend[a];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every negedge the DUT outputs must agree with the model.
    always @(negedge clk) begin
        checkOutput("cmp_rd_data1", {16'h0, rd_data1}, {16'h0, exp_data(rd_addr1)});
        checkOutput("cmp_rd_data2", {16'h0, rd_data2}, {16'h0, exp_data(rd_addr2)});
        checkOutput("cmp_pend1", {31'h0, pend1}, {31'h0, exp_pend(rd_addr1)});
        checkOutput("cmp_pend2", {31'h0, pend2}, {31'h0, exp_pend(rd_addr2)});
        checkOutput("cmp_clr_busy", {31'h0, clr_busy}, {31'h0, m_busy});
    end

    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic re, input logic [2:0] ra,
                                 input logic cr, input logic [2:0] a1, input logic [2:0] a2);
        @(posedge clk);
        #2;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; clr_req = cr;
        rd_addr1 = a1; rd_addr2 = a2;
    endtask

    task automatic idleRead(input logic [2:0] a1, input logic [2:0] a2);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, a1, a2);
        #1;
    endtask

    int busy_cnt;
    bit seen_busy;

    initial begin
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        idleRead(3'd3, 3'd7);
        checkOutput("reset_rd_data1", {16'h0, rd_data1}, 32'h0);
        checkOutput("reset_busy", {31'h0, clr_busy}, 32'h0);

        applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        applyStimulus(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        idleRead(3'd3, 3'd7);
        checkOutput("wr_r3", {16'h0, rd_data1}, 32'h1234);
        checkOutput("wr_r7", {16'h0, rd_data2}, 32'hBEEF);
        checkOutput("wr_pend", {30'h0, pend1, pend2}, 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_d1", {16'h0, rd_data1}, 32'h0);
        checkOutput("async_rst_d2", {16'h0, rd_data2}, 32'h0);
        reset_n = 1'b1;

        applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd5, 3'd0);
        idleRead(3'd5, 3'd0);
        checkOutput("rsv_r5_pend", {31'h0, pend1}, 32'h1);
        applyStimulus(1'b1, 3'd5, 16'h00AA, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        idleRead(3'd5, 3'd0);
        checkOutput("wb_r5_pend", {31'h0, pend1}, 32'h0);
        checkOutput("wb_r5_data", {16'h0, rd_data1}, 32'h00AA);

        applyStimulus(1'b1, 3'd2, 16'h5555, 1'b1, 3'd2, 1'b0, 3'd0, 3'd0);
        idleRead(3'd2, 3'd0);
        checkOutput("same_addr_data", {16'h0, rd_data1}, 32'h5555);
        checkOutput("same_addr_pend", {31'h0, pend1}, 32'h1);
        applyStimulus(1'b1, 3'd4, 16'h4444, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0);
        idleRead(3'd1, 3'd4);
        checkOutput("diff_rsv_pend", {31'h0, pend1}, 32'h1);
        checkOutput("diff_wr_pend", {31'h0, pend2}, 32'h0);

        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 3'(i), 16'h1110 + 16'(i), 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b0, 3'd6, 3'd0);
        idleRead(3'd6, 3'd0);
        checkOutput("fill_pend_r6", {31'h0, pend1}, 32'h1);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd6, 3'd7);
        busy_cnt = 0;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i == 3, 3'd0, 16'hFFFF, 1'b0, 3'd0, i == 5, 3'd0, 3'd7);
            #1;
            if (clr_busy) begin
                busy_cnt++;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                break;
            end
        end
        checkOutput("clr_busy_len", busy_cnt, 32'd8);
        for (int i = 0; i < 8; i += 2) begin
            idleRead(3'(i), 3'(i + 1));
            checkOutput("swept_data", {rd_data1, rd_data2}, 32'h0);
            checkOutput("swept_pend", {30'h0, pend1, pend2}, 32'h0);
        end

        applyStimulus(1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 1'b0, 3'd0, 3'd7);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd0, 3'd7);
        repeat (3) idleRead(3'd0, 3'd7);
        checkOutput("mid_sweep_busy", {31'h0, clr_busy}, 32'h1);
        checkOutput("mid_sweep_old", {16'h0, rd_data2}, 32'h7777);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_sweep_busy", {31'h0, clr_busy}, 32'h0);
        checkOutput("rst_sweep_r7", {16'h0, rd_data2}, 32'h0);
        reset_n = 1'b1;
        applyStimulus(1'b1, 3'd1, 16'h0101, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        idleRead(3'd1, 3'd0);
        checkOutput("post_rst_write", {16'h0, rd_data1}, 32'h0101);

        applyStimulus(1'b1, 3'd4, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        applyStimulus(1'b1, 3'd4, 16'hCAFE, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0);
        #1;
`ifdef RF_BYPASS_EN
        checkOutput("bypass_same_cycle", {16'h0, rd_data1}, 32'hCAFE);
`else
        checkOutput("no_bypass_same_cycle", {16'h0, rd_data1}, 32'h1111);
`endif
        idleRead(3'd4, 3'd0);
        checkOutput("write_next_cycle", {16'h0, rd_data1}, 32'hCAFE);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom),
                          ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 24) == 0),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        idleRead(3'd0, 3'd0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_multi.md
Name: rf_multi

Overview:
- Parametrised register file: `NUM_REGS` × `WORD_SIZE`, two asynchronous read ports, one synchronous write port.
- Adds a per-register pending scoreboard (reserve on issue, clear on writeback) and a sequential clear engine that zeroes the file one entry per cycle.
- Sits between decode/issue (reads, reservations) and writeback (writes) in the CPU datapath.

Parameters:
- WORD_SIZE, 16, data width in bits.
- NUM_REGS, 8, number of registers; power of two, ≥ 2.
- ADDR_W, 3, address width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_data1  output  WORD_SIZE  read port 1 data, combinational.
- pend1  output  1  pending bit of rd_addr1, combinational.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data2  output  WORD_SIZE  read port 2 data, combinational.
- pend2  output  1  pending bit of rd_addr2, combinational.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WORD_SIZE  write data.
- rsv_en  input  1  reserve strobe; marks rsv_addr pending.
- rsv_addr  input  ADDR_W  register to reserve.
- clr_req  input  1  single-cycle request to start a clear sweep.
- clr_busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers = 0, all pending bits = 0.
  - FSM = IDLE, sweep index = 0, clr_busy = 0.
  - rd_data1/2 and pend1/2 follow from the cleared state immediately.
- Reads:
  - rd_dataN = reg[rd_addrN] and pendN = pend[rd_addrN], combinational, zero latency.
  - Both ports may address the same register.
- Write (IDLE only):
  - On wr_en at a rising edge: reg[wr_addr] <= wr_data and pend[wr_addr] <= 0.
  - New value is visible on reads the cycle after the edge, unless RF_BYPASS_EN is defined.
- Reserve (IDLE only):
  - On rsv_en at a rising edge: pend[rsv_addr] <= 1.
  - Reserving an already pending register keeps it at 1.
- Write and reserve together:
  - Different addresses: both take effect.
  - Same address: data is written and the pending bit ends at 1 (reserve wins; a new producer has issued).
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clr_req. The request edge loads index = 0 and sets clr_busy = 1 from the next cycle.
  - Writes and reservations in the clr_req cycle are performed normally.
  - In CLEAR, each edge does reg[index] <= 0, pend[index] <= 0, index++.
  - When index = NUM_REGS-1 is cleared, FSM goes to IDLE and clr_busy drops. clr_busy is high for exactly NUM_REGS cycles.
  - wr_en and rsv_en are ignored in CLEAR: dropped, not queued.
  - clr_req is ignored in CLEAR.
  - Reads stay live during the sweep: entries not yet cleared return old data.
- Reset mid-sweep: immediate full clear, FSM = IDLE.
- Index wraps naturally at ADDR_W bits; no out-of-range addresses exist.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - If wr_en is high, FSM = IDLE and rd_addrN == wr_addr, then rd_dataN = wr_data and pendN = 0 in the same cycle (write-through forwarding).
  - If rsv_en also targets that address in the same cycle, pendN = 1.
  - No forwarding during CLEAR.
- Undefined: reads always return stored state; no forwarding path.

Test Plan:
- Reset → write 0x1234 to r3 and 0xBEEF to r7; read r3/r7 next cycle → rd_data1 = 0x1234, rd_data2 = 0xBEEF, pend1 = pend2 = 0; reset_n low asynchronously → both outputs read 0 before the next edge.
- rsv r5; next cycle read r5 → pend1 = 1; write r5 = 0x00AA → next cycle pend1 = 0, rd_data1 = 0x00AA.
- Same cycle rsv r2 and write r2 = 0x5555 → afterwards rd_data = 0x5555 and pend = 1; same cycle rsv r1 and write r4 → pend[r1] = 1, pend[r4] = 0.
- Fill all 8 regs and pend r6; pulse clr_req → clr_busy high exactly 8 cycles; wr_en r0 = 0xFFFF mid-sweep is dropped; afterwards all regs = 0, all pend = 0; clr_req during the sweep has no effect.
- Assert reset_n low at sweep cycle 3 → clr_busy = 0 at once, all regs 0; a write after release works normally.
- With RF_BYPASS_EN: write r4 = 0xCAFE with rd_addr1 = 4 in the same cycle → rd_data1 = 0xCAFE that cycle. Without it → old value that cycle, 0xCAFE next cycle.
